// File: rtl/kmb_pkg.sv
// Shared definitions for the kernel memory bridge: FSM state codes and the
// width helper for the kernel clock-enable divider.
package kmb_pkg;

    typedef logic [2:0] kmb_state_t;

    localparam kmb_state_t S_IDLE  = 3'd0;
    localparam kmb_state_t S_LOAD  = 3'd1;
    localparam kmb_state_t S_RUN   = 3'd2;
    localparam kmb_state_t S_STORE = 3'd3;
    localparam kmb_state_t S_DONE  = 3'd4;
    localparam kmb_state_t S_ERR   = 3'd5;

    // Divider counter width; a period of 1 still needs a one-bit counter.
    function automatic int kdiv_wid(input int kdiv);
        return (kdiv > 1) ? $clog2(kdiv) : 1;
    endfunction

endpackage

// File: rtl/kmb_dpram.sv
// Scratchpad with two read/write ports. Reads are registered and return the
// contents from before any write in the same cycle; when both ports write one
// address, port 1's data is kept. Read data holds until the next read on
// that port.
module kmb_dpram #(
    parameter int DATA_WID = 32,
    parameter int ADDR_WID = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce0,
    input  logic                we0,
    input  logic [ADDR_WID-1:0] addr0,
    input  logic [DATA_WID-1:0] d0,
    output logic [DATA_WID-1:0] q0,
    input  logic                ce1,
    input  logic                we1,
    input  logic [ADDR_WID-1:0] addr1,
    input  logic [DATA_WID-1:0] d1,
    output logic [DATA_WID-1:0] q1,
    output logic                wr_clash
);

    localparam int DEPTH = 1 << ADDR_WID;

    logic [DATA_WID-1:0] mem_q [DEPTH];
    logic [DATA_WID-1:0] q0_q, q0_d;
    logic [DATA_WID-1:0] q1_q, q1_d;

    // Read data is captured only on a serviced read, otherwise held.
    always_comb begin
        q0_d = q0_q;
        q1_d = q1_q;
        if (ce0 && !we0) q0_d = mem_q[addr0];
        if (ce1 && !we1) q1_d = mem_q[addr1];
    end

    // Read registers, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q0_q <= '0;
            q1_q <= '0;
        end else begin
            q0_q <= q0_d;
            q1_q <= q1_d;
        end
    end

    // Array writes; port 1 is written last so it wins a same-address clash.
    always_ff @(posedge clk) begin
        if (ce0 && we0) mem_q[addr0] <= d0;
        if (ce1 && we1) mem_q[addr1] <= d1;
    end

    assign wr_clash = ce0 && we0 && ce1 && we1 && (addr0 == addr1);
    assign q0       = q0_q;
    assign q1       = q1_q;

endmodule

// File: rtl/kernel_mem_bridge.sv
// Host-to-kernel staging bridge: loads num_words from host memory into the
// scratchpad, lets an HLS kernel work on it through two memory ports under a
// divided clock enable, then writes the scratchpad back to host memory.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; outputs quiet, cycles frozen
// LOAD    | rd_req high, one scratchpad write per rd_valid
// RUN     | kernel active, ports serviced on k_ce cycles only
// STORE   | alternate fetch (wr_req low) and present (wr_req high) cycles
// DONE    | one-cycle done pulse
// ERR     | one-cycle error pulse for an out-of-range length
module kernel_mem_bridge
    import kmb_pkg::*;
#(
    parameter int DATA_WID = 32,
    parameter int ADDR_WID = 12,
    parameter int KDIV     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [63:0]         read_base,
    input  logic [63:0]         write_base,
    input  logic [63:0]         num_words,
    input  logic [63:0]         stride,
    output logic                rd_req,
    output logic [63:0]         rd_addr,
    input  logic                rd_valid,
    input  logic [DATA_WID-1:0] rd_data,
    output logic                wr_req,
    output logic [63:0]         wr_addr,
    output logic [DATA_WID-1:0] wr_data,
    input  logic                wr_ack,
    output logic                k_ce,
    output logic                k_start,
    input  logic                k_done,
    input  logic                k_ce0,
    input  logic                k_we0,
    input  logic [ADDR_WID-1:0] k_addr0,
    input  logic [DATA_WID-1:0] k_d0,
    output logic [DATA_WID-1:0] k_q0,
    input  logic                k_ce1,
    input  logic                k_we1,
    input  logic [ADDR_WID-1:0] k_addr1,
    input  logic [DATA_WID-1:0] k_d1,
    output logic [DATA_WID-1:0] k_q1,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                collision,
    output logic [63:0]         cycles
);

    localparam int                DIV_W    = kdiv_wid(KDIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(KDIV - 1);
    localparam logic [63:0]       DEPTH    = 64'd1 << ADDR_WID;

    kmb_state_t          state_q, state_d;
    logic [ADDR_WID-1:0] cnt_q, cnt_d;
    logic [ADDR_WID-1:0] num_m1_q, num_m1_d;
    logic [63:0]         stride_q, stride_d;
    logic [63:0]         wbase_q, wbase_d;
    logic [63:0]         rd_addr_q, rd_addr_d;
    logic [63:0]         wr_addr_q, wr_addr_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                fetch_q, fetch_d;
    logic                collision_q, collision_d;
    logic [63:0]         cycles_q, cycles_d;

    logic                k_ce_w;
    logic                len_ok;
    logic                last_word;
    logic                p0_ce, p0_we, p1_ce;
    logic [ADDR_WID-1:0] p0_addr;
    logic [DATA_WID-1:0] p0_d;
    logic [DATA_WID-1:0] q0_w;
    logic                wr_clash;

    assign k_ce_w    = (state_q == S_RUN) && (div_q == '0);
    assign len_ok    = (num_words != 64'd0) && (num_words <= DEPTH);
    assign last_word = (cnt_q == num_m1_q);

    // Port 0 is shared: host writes in LOAD, kernel in RUN, host reads in STORE.
    always_comb begin
        p0_ce   = 1'b0;
        p0_we   = 1'b0;
        p0_addr = cnt_q;
        p0_d    = rd_data;
        case (state_q)
            S_LOAD: begin
                p0_ce = rd_valid;
                p0_we = 1'b1;
            end
            S_RUN: begin
                p0_ce   = k_ce_w && k_ce0;
                p0_we   = k_we0;
                p0_addr = k_addr0;
                p0_d    = k_d0;
            end
            S_STORE: p0_ce = fetch_q;
            default: ;
        endcase
    end

    assign p1_ce = k_ce_w && k_ce1;

    kmb_dpram #(
        .DATA_WID (DATA_WID),
        .ADDR_WID (ADDR_WID)
    ) u_dpram (
        .clk      (clk),
        .reset    (reset),
        .ce0      (p0_ce),
        .we0      (p0_we),
        .addr0    (p0_addr),
        .d0       (p0_d),
        .q0       (q0_w),
        .ce1      (p1_ce),
        .we1      (k_we1),
        .addr1    (k_addr1),
        .d1       (k_d1),
        .q1       (k_q1),
        .wr_clash (wr_clash)
    );

    // Sequencer next-state, address generators, divider and cycle counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        num_m1_d    = num_m1_q;
        stride_d    = stride_q;
        wbase_d     = wbase_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        div_d       = div_q;
        fetch_d     = fetch_q;
        collision_d = collision_q || wr_clash;
        cycles_d    = (state_q != S_IDLE) ? cycles_q + 64'd1 : cycles_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cycles_d = 64'd0;
                    if (len_ok) begin
                        state_d     = S_LOAD;
                        num_m1_d    = ADDR_WID'(num_words - 64'd1);
                        stride_d    = stride;
                        wbase_d     = write_base;
                        rd_addr_d   = read_base;
                        cnt_d       = '0;
                        collision_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_LOAD: begin
                if (rd_valid) begin
                    cnt_d     = cnt_q + ADDR_WID'(1);
                    rd_addr_d = rd_addr_q + stride_q;
                    if (last_word) begin
                        cnt_d   = '0;
                        div_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                div_d = (div_q == '0) ? DIV_LAST : div_q - DIV_W'(1);
                if (k_ce_w && k_done) begin
                    state_d   = S_STORE;
                    cnt_d     = '0;
                    fetch_d   = 1'b1;
                    wr_addr_d = wbase_q;
                end
            end
            S_STORE: begin
                if (fetch_q) begin
                    fetch_d = 1'b0;
                end else if (wr_ack) begin
                    if (last_word) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d     = cnt_q + ADDR_WID'(1);
                        wr_addr_d = wr_addr_q + stride_q;
                        fetch_d   = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and datapath registers; reset drops every request immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            num_m1_q    <= '0;
            stride_q    <= '0;
            wbase_q     <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            div_q       <= '0;
            fetch_q     <= 1'b0;
            collision_q <= 1'b0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            num_m1_q    <= num_m1_d;
            stride_q    <= stride_d;
            wbase_q     <= wbase_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            div_q       <= div_d;
            fetch_q     <= fetch_d;
            collision_q <= collision_d;
            cycles_q    <= cycles_d;
        end
    end

    assign rd_req    = (state_q == S_LOAD);
    assign rd_addr   = rd_addr_q;
    assign wr_req    = (state_q == S_STORE) && !fetch_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = q0_w;
    assign k_q0      = q0_w;
    assign k_ce      = k_ce_w;
    assign k_start   = (state_q == S_RUN);
    assign busy      = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_STORE);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERR);
    assign collision = collision_q;
    assign cycles    = cycles_q;

endmodule
